// File: rtl/wgt_load_sched.sv
// Weight-load scheduler: runs img2col_weight once per output-channel group, ping-ponging two
// weight buffers with the PE array. Define WGT_LOAD_SCHED_PERF_EN to enable the stall counter.
module wgt_load_sched #(
    parameter int unsigned GRP_W  = 8,
    parameter int unsigned CHN_W  = 7,
    parameter int unsigned KS_W   = 4,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned PERF_W = 16
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [GRP_W-1:0]  cfg_grp_num,
    input  logic [CHN_W-1:0]  cfg_chn_num,
    input  logic [KS_W-1:0]   cfg_kernel,
    output logic              i2c_wgt_start,
    output logic              i2c_chn_sel,
    output logic [CHN_W-1:0]  chn_num,
    output logic [KS_W-1:0]   kernel_size,
    output logic [ADDR_W-1:0] i2c_base_addr,
    input  logic              i2c_ready,
    output logic [1:0]        pe_buf_valid,
    input  logic [1:0]        pe_buf_done,
    output logic              layer_done,
    output logic              busy,
    output logic [PERF_W-1:0] stall_cycles
);

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StWaitBuf,
        StStart,
        StWaitRdy,
        StRelease,
        StDrain
    } state_e;

    state_e            state_q, state_d;
    logic [GRP_W-1:0]  grp_num_q, grp_num_d;
    logic [GRP_W-1:0]  grp_idx_q, grp_idx_d;
    logic [CHN_W-1:0]  chn_num_q, chn_num_d;
    logic [KS_W-1:0]   kernel_q, kernel_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        buf_valid_q, buf_valid_d;
    logic              load_set;
    logic [ADDR_W-1:0] addr_step;

    // Base address advances by one group's word count, wrapping mod 2^ADDR_W.
    assign addr_step = ADDR_W'(chn_num_q) + ADDR_W'(1);

    always_comb begin
        state_d       = state_q;
        grp_num_d     = grp_num_q;
        grp_idx_d     = grp_idx_q;
        chn_num_d     = chn_num_q;
        kernel_d      = kernel_q;
        base_d        = base_q;
        wr_ptr_d      = wr_ptr_q;
        load_set      = 1'b0;
        i2c_wgt_start = 1'b0;
        layer_done    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cfg_valid) begin
                    grp_num_d = cfg_grp_num;
                    chn_num_d = cfg_chn_num;
                    kernel_d  = cfg_kernel;
                    grp_idx_d = '0;
                    wr_ptr_d  = 1'b0;
                    base_d    = '0;
                    state_d   = StCheck;
                end
            end
            StCheck: begin
                state_d = buf_valid_q[wr_ptr_q] ? StWaitBuf : StStart;
            end
            StWaitBuf: begin
                if (!buf_valid_q[wr_ptr_q]) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                i2c_wgt_start = 1'b1;
                state_d       = StWaitRdy;
            end
            StWaitRdy: begin
                i2c_wgt_start = 1'b1;
                if (i2c_ready) begin
                    load_set = 1'b1;
                    state_d  = StRelease;
                end
            end
            StRelease: begin
                // Ready is a level; wait for it to fall so a held level cannot re-trigger.
                if (!i2c_ready) begin
                    if (grp_idx_q == grp_num_q) begin
                        state_d = StDrain;
                    end else begin
                        grp_idx_d = grp_idx_q + GRP_W'(1);
                        wr_ptr_d  = ~wr_ptr_q;
                        base_d    = base_q + addr_step;
                        state_d   = StCheck;
                    end
                end
            end
            StDrain: begin
                if (buf_valid_q == 2'b00) begin
                    layer_done = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A completed fill overrides a same-cycle release of that buffer.
        buf_valid_d = buf_valid_q & ~pe_buf_done;
        if (load_set) begin
            buf_valid_d[wr_ptr_q] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= StIdle;
            grp_num_q   <= '0;
            grp_idx_q   <= '0;
            chn_num_q   <= '0;
            kernel_q    <= '0;
            base_q      <= '0;
            wr_ptr_q    <= 1'b0;
            buf_valid_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            grp_num_q   <= grp_num_d;
            grp_idx_q   <= grp_idx_d;
            chn_num_q   <= chn_num_d;
            kernel_q    <= kernel_d;
            base_q      <= base_d;
            wr_ptr_q    <= wr_ptr_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    assign cfg_ready     = (state_q == StIdle);
    assign busy          = (state_q != StIdle);
    assign i2c_chn_sel   = wr_ptr_q;
    assign chn_num       = chn_num_q;
    assign kernel_size   = kernel_q;
    assign i2c_base_addr = base_q;
    assign pe_buf_valid  = buf_valid_q;

`ifdef WGT_LOAD_SCHED_PERF_EN
    logic [PERF_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == StIdle && cfg_valid) begin
            stall_d = '0;
        end else if (state_q == StWaitBuf && stall_q != '1) begin
            stall_d = stall_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_wgt_load_sched.sv
// Randomized bench for wgt_load_sched: a sequential reference thread predicts every output each
// cycle; directed layers pin chn_sel/base_addr sequences, stalls and mid-layer reset.
module tb_wgt_load_sched;

    logic       clock;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_grp_num;
    logic [6:0] cfg_chn_num;
    logic [3:0] cfg_kernel;
    logic       i2c_wgt_start;
    logic       i2c_chn_sel;
    logic [6:0] chn_num;
    logic [3:0] kernel_size;
    logic [7:0] i2c_base_addr;
    logic       i2c_ready;
    logic [1:0] pe_buf_valid;
    logic [1:0] pe_buf_done;
    logic       layer_done;
    logic       busy;
    logic [15:0] stall_cycles;

    wgt_load_sched dut (
        .clock         (clock),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_grp_num   (cfg_grp_num),
        .cfg_chn_num   (cfg_chn_num),
        .cfg_kernel    (cfg_kernel),
        .i2c_wgt_start (i2c_wgt_start),
        .i2c_chn_sel   (i2c_chn_sel),
        .chn_num       (chn_num),
        .kernel_size   (kernel_size),
        .i2c_base_addr (i2c_base_addr),
        .i2c_ready     (i2c_ready),
        .pe_buf_valid  (pe_buf_valid),
        .pe_buf_done   (pe_buf_done),
        .layer_done    (layer_done),
        .busy          (busy),
        .stall_cycles  (stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit         model_live = 1'b0;
    bit         aborted;
    logic       e_start, e_sel, e_done, e_busy;
    logic [6:0] e_chn;
    logic [3:0] e_ks;
    logic [7:0] e_base;
    logic [1:0] e_valid;
    logic [15:0] e_stall;
    int         m_grp, m_chn;
    logic       m_ptr;
    logic       smp_rst, smp_rdy, smp_cfgv;
    logic [1:0] smp_done;
    logic [7:0] smp_grp;
    logic [6:0] smp_chn;
    logic [3:0] smp_ks;

    // Advance one clock edge, applying reset and PE releases seen at that edge.
    task automatic tick();
        @(posedge clock);
        smp_rst  = rst;
        smp_rdy  = i2c_ready;
        smp_done = pe_buf_done;
        smp_cfgv = cfg_valid;
        smp_grp  = cfg_grp_num;
        smp_chn  = cfg_chn_num;
        smp_ks   = cfg_kernel;
        model_live = 1'b1;
        if (smp_rst) begin
            aborted = 1'b1;
            e_start = 0; e_busy = 0; e_done = 0; e_valid = 0;
            e_chn = 0; e_ks = 0; e_base = 0; e_stall = 0; m_ptr = 0;
        end else begin
            e_valid = e_valid & ~smp_done;
        end
    endtask

    task automatic run_layer();
        bit w;
        for (int g = 0; g <= m_grp; g++) begin
            e_busy  = 1'b1;
            e_start = 1'b0;
            w = e_valid[m_ptr];
            tick(); if (aborted) return;
            while (w) begin
                w = e_valid[m_ptr];
                tick(); if (aborted) return;
`ifdef WGT_LOAD_SCHED_PERF_EN
                if (e_stall != 16'hffff) e_stall = e_stall + 16'd1;
`endif
            end
            e_start = 1'b1;
            e_sel   = m_ptr;
            tick(); if (aborted) return;
            do begin
                tick(); if (aborted) return;
            end while (!smp_rdy);
            e_valid[m_ptr] = 1'b1;
            e_start = 1'b0;
            do begin
                tick(); if (aborted) return;
            end while (smp_rdy);
            if (g < m_grp) begin
                m_ptr  = ~m_ptr;
                e_base = 8'(((g + 1) * (m_chn + 1)) % 256);
            end
        end
        do begin
            e_done = (e_valid == 2'b00);
            w = e_done;
            tick(); if (aborted) return;
        end while (!w);
        e_done = 1'b0;
        e_busy = 1'b0;
    endtask

    initial begin
        e_start = 0; e_sel = 0; e_done = 0; e_busy = 0; e_chn = 0; e_ks = 0;
        e_base = 0; e_valid = 0; e_stall = 0; m_ptr = 0; m_grp = 0; m_chn = 0;
        forever begin
            aborted = 1'b0;
            e_busy = 1'b0; e_start = 1'b0; e_done = 1'b0;
            tick();
            if (!aborted && smp_cfgv) begin
                m_grp = int'(smp_grp);
                m_chn = int'(smp_chn);
                e_chn = smp_chn;
                e_ks  = smp_ks;
                m_ptr = 1'b0;
                e_base = 8'd0;
                e_stall = 16'd0;
                run_layer();
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clock);
            if (model_live) begin
                chk("cfg_ready", cfg_ready, !e_busy);
                chk("busy", busy, e_busy);
                chk("i2c_wgt_start", i2c_wgt_start, e_start);
                if (e_start) chk("i2c_chn_sel", i2c_chn_sel, e_sel);
                chk("chn_num", chn_num, e_chn);
                chk("kernel_size", kernel_size, e_ks);
                chk("i2c_base_addr", i2c_base_addr, e_base);
                chk("pe_buf_valid", pe_buf_valid, e_valid);
                chk("layer_done", layer_done, e_done);
                chk("stall_cycles", stall_cycles, e_stall);
            end
        end
    end

    // ---------------- monitor ----------------
    bit         st_sel[$];
    logic [7:0] st_base[$];
    logic [1:0] valid_or;
    int         done_cnt = 0;

    initial begin
        bit prev = 1'b0;
        valid_or = 2'b00;
        forever begin
            @(negedge clock);
            if (i2c_wgt_start === 1'b1 && !prev) begin
                st_sel.push_back(i2c_chn_sel);
                st_base.push_back(i2c_base_addr);
            end
            prev = (i2c_wgt_start === 1'b1);
            if (pe_buf_valid !== 2'bxx) valid_or = valid_or | pe_buf_valid;
            if (layer_done === 1'b1) done_cnt++;
        end
    end

    // ---------------- responders ----------------
    int rdy_dmin = 0, rdy_dmax = 3, hold_max = 1;
    int pe_dmin = 0, pe_dmax = 3;
    bit noise_en = 1'b0;

    initial begin
        bit r_armed = 1'b0;
        int r_cnt = 0, r_hold = 0;
        bit p_pend[2] = '{1'b0, 1'b0};
        int p_cnt[2] = '{0, 0};
        i2c_ready   = 1'b0;
        pe_buf_done = 2'b00;
        forever begin
            @(posedge clock);
            #2;
            if (r_armed) begin
                if (r_cnt > 0) r_cnt--;
                else if (r_hold > 0) begin
                    i2c_ready = 1'b1;
                    r_hold--;
                end else begin
                    i2c_ready = 1'b0;
                    r_armed = 1'b0;
                end
            end else if (i2c_wgt_start === 1'b1) begin
                r_armed = 1'b1;
                r_cnt   = int'($urandom_range(rdy_dmax, rdy_dmin));
                r_hold  = int'($urandom_range(hold_max, 1));
            end
            for (int b = 0; b < 2; b++) begin
                pe_buf_done[b] = 1'b0;
                if (p_pend[b]) begin
                    if (p_cnt[b] == 0) begin
                        pe_buf_done[b] = 1'b1;
                        p_pend[b] = 1'b0;
                    end else p_cnt[b]--;
                end else if (pe_buf_valid[b] === 1'b1) begin
                    p_pend[b] = 1'b1;
                    p_cnt[b]  = int'($urandom_range(pe_dmax, pe_dmin));
                end else if (noise_en && $urandom_range(7, 0) == 0) begin
                    pe_buf_done[b] = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_cfg(input int grp, input int chn, input int ks, input bit junk);
        st_sel.delete();
        st_base.delete();
        valid_or = 2'b00;
        @(posedge clock); #2;
        cfg_valid = 1'b1;
        cfg_grp_num = 8'(grp);
        cfg_chn_num = 7'(chn);
        cfg_kernel = 4'(ks);
        @(posedge clock); #2;
        if (junk) begin
            cfg_grp_num = 8'($urandom);
            cfg_chn_num = 7'($urandom);
            cfg_kernel = 4'($urandom);
            @(posedge clock); #2;
        end
        cfg_valid = 1'b0;
    endtask

    task automatic do_layer(input string tag, input int grp, input int chn, input int ks,
                            input bit junk);
        bit seen = 1'b0;
        int d0 = done_cnt;
        start_cfg(grp, chn, ks, junk);
        for (int i = 0; i < 20000 && !seen; i++) begin
            @(negedge clock);
            if (layer_done === 1'b1) seen = 1'b1;
        end
        chk({tag, "_layer_done_seen"}, seen, 1);
        chk({tag, "_start_count"}, st_sel.size(), grp + 1);
        @(negedge clock);
        chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    endtask

    initial begin
        logic [7:0] t2_base[4] = '{8'd0, 8'd108, 8'd216, 8'd68};
        bit         t2_sel[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        bit found;
        int d0;
        rst = 1'b1; cfg_valid = 1'b0; cfg_grp_num = 0; cfg_chn_num = 0; cfg_kernel = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_pe_buf_valid", pe_buf_valid, 0);
        chk("rst_start", i2c_wgt_start, 0);
        @(posedge clock); #2;
        rst = 1'b0;

        // T1: single group, ready 20 cycles after start
        rdy_dmin = 19; rdy_dmax = 19; hold_max = 1; pe_dmin = 2; pe_dmax = 4; noise_en = 0;
        do_layer("t1", 0, 107, 3, 0);
        chk("t1_sel", st_sel.size() > 0 ? st_sel[0] : 1'bx, 0);
        chk("t1_valid_seen", valid_or, 2'b01);
        chk("t1_chn_num", chn_num, 107);
        chk("t1_kernel", kernel_size, 3);

        // T2: four groups, PE consumes immediately
        rdy_dmin = 0; rdy_dmax = 3; hold_max = 2; pe_dmin = 0; pe_dmax = 0;
        do_layer("t2", 3, 107, 3, 1);
        for (int i = 0; i < 4; i++) begin
            if (i < st_sel.size()) begin
                chk($sformatf("t2_sel%0d", i), st_sel[i], t2_sel[i]);
                chk($sformatf("t2_base%0d", i), st_base[i], t2_base[i]);
            end
        end

        // T3: PE withholds buffers, third fill must stall
        rdy_dmin = 0; rdy_dmax = 2; hold_max = 1; pe_dmin = 50; pe_dmax = 50;
        do_layer("t3", 2, 20, 5, 0);
`ifdef WGT_LOAD_SCHED_PERF_EN
        chk("t3_stall_nonzero", stall_cycles != 16'd0, 1);
`else
        chk("t3_stall_tied", stall_cycles, 0);
`endif

        // T4: ready held for 10 cycles
        rdy_dmin = 0; rdy_dmax = 3; hold_max = 10; pe_dmin = 0; pe_dmax = 5;
        do_layer("t4", 4, 11, 1, 0);

        // T5: reset during WAIT_RDY of group 1
        rdy_dmin = 8; rdy_dmax = 8; hold_max = 1; pe_dmin = 0; pe_dmax = 2;
        start_cfg(3, 30, 3, 0);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clock);
            if (i2c_wgt_start === 1'b1 && i2c_chn_sel === 1'b1) found = 1'b1;
        end
        chk("t5_reached_grp1", found, 1);
        @(negedge clock);
        chk("t5_in_wait_rdy", i2c_wgt_start, 1);
        d0 = done_cnt;
        @(posedge clock); #2;
        rst = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("t5_cfg_ready", cfg_ready, 1);
        chk("t5_pe_buf_valid", pe_buf_valid, 0);
        chk("t5_busy", busy, 0);
        @(posedge clock); #2;
        rst = 1'b0;
        repeat (30) @(posedge clock);
        chk("t5_no_layer_done", done_cnt - d0, 0);

        // Randomized layers with spurious PE releases (covers same-cycle refill/release)
        noise_en = 1'b1;
        for (int n = 0; n < 14; n++) begin
            rdy_dmin = 0;
            rdy_dmax = int'($urandom_range(6, 0));
            hold_max = int'($urandom_range(4, 1));
            pe_dmin  = 0;
            pe_dmax  = int'($urandom_range(12, 0));
            do_layer($sformatf("rnd%0d", n), int'($urandom_range(6, 0)),
                     int'($urandom_range(127, 0)), int'($urandom_range(15, 0)),
                     1'($urandom_range(1, 0)));
        end

        repeat (3) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
